// File: rtl/uart_pkg.sv
// Shared constants and types for the Avalon-MM UART transmitter.
package uart_pkg;
  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_TXDATA  = 4'd1;
  localparam logic [3:0] ADDR_CTRL    = 4'd2;
  localparam logic [3:0] ADDR_SCRATCH = 4'd3;

  localparam int TX_EN_BIT = 0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_core_if.sv
// Avalon-MM slave bundle for the UART transmitter, including the TX ready flag.
interface uart_tx_core_if;
  logic [3:0] avms_address_i;
  logic       avms_read_i;
  logic       avms_write_i;
  logic [7:0] avms_writedata_i;
  logic       ready;
  logic [7:0] avms_readdata_o;

  modport slave  (input  avms_address_i, avms_read_i, avms_write_i, avms_writedata_i,
                  output ready, avms_readdata_o);
  modport master (output avms_address_i, avms_read_i, avms_write_i, avms_writedata_i,
                  input  ready, avms_readdata_o);
endinterface

// File: rtl/uart_tx_shift.sv
// 8N1 serializer: baud counter, frame FSM and shift register.
module uart_tx_shift
  import uart_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       take_o,
  output logic       busy_o,
  output logic       txd_o
);
  localparam int CW = $clog2(DIV);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          tc;

  assign tc = (cnt_q == CW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    take_o  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load_i) begin
          take_o  = 1'b1;
          sh_d    = data_i;
          state_d = START;
        end
      end
      START: if (tc) begin
        cnt_d   = '0;
        bit_d   = 3'd0;
        state_d = DATA;
      end
      DATA: if (tc) begin
        cnt_d = '0;
        sh_d  = sh_q >> 1;
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      STOP: if (tc) begin
        cnt_d = '0;
        // Chain straight into the next frame when a byte is already waiting.
        if (load_i) begin
          take_o  = 1'b1;
          sh_d    = data_i;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level follows the state being entered so txd comes straight off a flop.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign txd_o  = txd_q;
endmodule

// File: rtl/uart_tx_core.sv
// Avalon-MM UART transmitter: register decode, holding register, and the serializer.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  uart_tx_core_if.slave  avms,
  output logic           uart_txd_o
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;

  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_q;
  logic       ready_q;
  logic       tx_en_q;
  logic [7:0] scratch_q;
  logic [7:0] rdata_q, rdata_d;
  logic       wr_tx, wr_ctrl, wr_scr;
  logic       take, busy;

  assign wr_tx   = avms.avms_write_i && (avms.avms_address_i == ADDR_TXDATA) && ready_q;
  assign wr_ctrl = avms.avms_write_i && (avms.avms_address_i == ADDR_CTRL);
  assign wr_scr  = avms.avms_write_i && (avms.avms_address_i == ADDR_SCRATCH);

  // ready is a flop of "holding empty next cycle", so it is 0 in reset and rises on the first edge.
  always_comb begin
    hold_full_d = hold_full_q;
    if (wr_tx)     hold_full_d = 1'b1;
    else if (take) hold_full_d = 1'b0;
  end

  always_comb begin
    rdata_d = '0;
    case (avms.avms_address_i)
      ADDR_STATUS:  rdata_d = {6'b0, busy, ready_q};
      ADDR_TXDATA:  rdata_d = hold_q;
      ADDR_CTRL:    rdata_d = {7'b0, tx_en_q};
      ADDR_SCRATCH: rdata_d = scratch_q;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      ready_q     <= 1'b0;
      tx_en_q     <= 1'b1;
      scratch_q   <= '0;
      rdata_q     <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      if (wr_tx)   hold_q    <= avms.avms_writedata_i;
      if (wr_ctrl) tx_en_q   <= avms.avms_writedata_i[TX_EN_BIT];
      if (wr_scr)  scratch_q <= avms.avms_writedata_i;
      if (avms.avms_read_i) rdata_q <= rdata_d;
    end
  end

  uart_tx_shift #(.DIV(DIV)) u_shift (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .load_i   (hold_full_q && tx_en_q),
    .data_i   (hold_q),
    .take_o   (take),
    .busy_o   (busy),
    .txd_o    (uart_txd_o)
  );

  assign avms.ready           = ready_q;
  assign avms.avms_readdata_o = rdata_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: reset, framing, back-to-back, TX_EN gating, reads, mid-frame reset.
module tb_uart_tx_core;
  import uart_pkg::*;

  localparam int DIV = 868;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic txd;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_tx_core_if bus();

  uart_tx_core #(.CLK_FREQ(100_000_000), .BAUD(115_200)) dut (
    .clk_i      (clk),
    .arst_n_i   (arst_n),
    .avms       (bus),
    .uart_txd_o (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.avms_address_i   = a;
    bus.avms_writedata_i = d;
    bus.avms_write_i     = 1'b1;
    @(negedge clk);
    bus.avms_write_i     = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.avms_address_i = a;
    bus.avms_read_i    = 1'b1;
    @(negedge clk);
    bus.avms_read_i    = 1'b0;
    chk(tag, bus.avms_readdata_o, exp);
  endtask

  // Cursor sits in cycle c0 of the start bit; checks first and last cycle of every bit.
  task automatic frame_chk(input logic [7:0] b, input int c0, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (!(i == 0 && c0 > 0)) chk($sformatf("%s b%0d first", tag, i), 8'(txd), 8'(bits[i]));
      for (int c = (i == 0) ? c0 + 1 : 1; c < DIV; c++) begin
        if (i == 4 && c == 10) begin
          bus.avms_address_i = ADDR_STATUS;
          bus.avms_read_i    = 1'b1;
        end
        @(negedge clk);
        if (i == 4 && c == 10) begin
          bus.avms_read_i = 1'b0;
          chk({tag, " busy"}, 8'(bus.avms_readdata_o[1]), 8'd1);
        end
      end
      chk($sformatf("%s b%0d last", tag, i), 8'(txd), 8'(bits[i]));
      if (i < 9) @(negedge clk);
    end
  endtask

  initial begin
    int low_seen;
    bus.avms_address_i   = '0;
    bus.avms_read_i      = 1'b0;
    bus.avms_write_i     = 1'b0;
    bus.avms_writedata_i = '0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst txd", 8'(txd), 8'd1);
    chk("rst ready", 8'(bus.ready), 8'd0);
    chk("rst rdata", bus.avms_readdata_o, 8'h00);
    arst_n = 1'b1;
    #1 chk("rel ready0", 8'(bus.ready), 8'd0);
    @(negedge clk);
    chk("rel ready1", 8'(bus.ready), 8'd1);

    // Single frame 0x13
    bus.avms_address_i   = ADDR_TXDATA;
    bus.avms_writedata_i = 8'h13;
    bus.avms_write_i     = 1'b1;
    @(negedge clk);
    bus.avms_write_i = 1'b0;
    chk("f13 ready0", 8'(bus.ready), 8'd0);
    chk("f13 pre txd", 8'(txd), 8'd1);
    @(negedge clk);
    chk("f13 ready1", 8'(bus.ready), 8'd1);
    frame_chk(8'h13, 0, "f13");
    @(negedge clk);
    chk("f13 idle txd", 8'(txd), 8'd1);
    rd(ADDR_STATUS, 8'h01, "st idle");

    // Back-to-back 0x19, 0x21; 0x77 written while ready=0 must vanish
    bus.avms_address_i   = ADDR_TXDATA;
    bus.avms_writedata_i = 8'h19;
    bus.avms_write_i     = 1'b1;
    @(negedge clk);
    bus.avms_write_i = 1'b0;
    chk("b2b ready0", 8'(bus.ready), 8'd0);
    @(negedge clk);
    chk("b2b ready1", 8'(bus.ready), 8'd1);
    bus.avms_writedata_i = 8'h21;
    bus.avms_write_i     = 1'b1;
    @(negedge clk);
    chk("b2b hold full", 8'(bus.ready), 8'd0);
    bus.avms_writedata_i = 8'h77;
    @(negedge clk);
    bus.avms_write_i = 1'b0;
    bus.avms_read_i  = 1'b1;
    @(negedge clk);
    bus.avms_read_i = 1'b0;
    chk("drop txdata", bus.avms_readdata_o, 8'h21);
    chk("drop ready", 8'(bus.ready), 8'd0);
    frame_chk(8'h19, 3, "f19");
    @(negedge clk);
    chk("f21 ready", 8'(bus.ready), 8'd1);
    frame_chk(8'h21, 0, "f21");
    low_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    chk("no 3rd frame", 8'(low_seen), 8'd0);
    rd(ADDR_STATUS, 8'h01, "st after b2b");

    // TX_EN gating
    wr(ADDR_CTRL, 8'h00);
    wr(ADDR_TXDATA, 8'h55);
    chk("dis ready", 8'(bus.ready), 8'd0);
    repeat (50) @(negedge clk);
    chk("dis txd", 8'(txd), 8'd1);
    rd(ADDR_STATUS, 8'h00, "dis status");
    rd(ADDR_CTRL, 8'h00, "dis ctrl");
    bus.avms_address_i   = ADDR_CTRL;
    bus.avms_writedata_i = 8'h01;
    bus.avms_write_i     = 1'b1;
    @(negedge clk);
    bus.avms_write_i = 1'b0;
    chk("en +1 txd", 8'(txd), 8'd1);
    @(negedge clk);
    chk("en +2 ready", 8'(bus.ready), 8'd1);
    frame_chk(8'h55, 0, "f55");
    @(negedge clk);

    // Register reads
    wr(ADDR_SCRATCH, 8'hA5);
    rd(ADDR_SCRATCH, 8'hA5, "scratch");
    @(negedge clk);
    chk("rdata hold", bus.avms_readdata_o, 8'hA5);
    rd(4'd9, 8'h00, "addr9");
    wr(ADDR_CTRL, 8'hFF);
    rd(ADDR_CTRL, 8'h01, "ctrl rsvd");
    bus.avms_address_i   = ADDR_SCRATCH;
    bus.avms_writedata_i = 8'h3C;
    bus.avms_write_i     = 1'b1;
    bus.avms_read_i      = 1'b1;
    @(negedge clk);
    bus.avms_write_i = 1'b0;
    bus.avms_read_i  = 1'b0;
    chk("rw prewrite", bus.avms_readdata_o, 8'hA5);
    wr(4'd9, 8'hFF);
    rd(ADDR_SCRATCH, 8'h3C, "rw postwrite");

    // Reset in the middle of DATA with a byte pending
    wr(ADDR_TXDATA, 8'h0F);
    @(negedge clk);
    chk("r0f start", 8'(txd), 8'd0);
    repeat (3 * DIV) @(negedge clk);
    chk("r0f b2", 8'(txd), 8'd1);
    wr(ADDR_TXDATA, 8'hAA);
    chk("r pend ready", 8'(bus.ready), 8'd0);
    rd(ADDR_SCRATCH, 8'h3C, "r pre scratch");
    arst_n = 1'b0;
    #1;
    chk("mid rst txd", 8'(txd), 8'd1);
    chk("mid rst ready", 8'(bus.ready), 8'd0);
    chk("mid rst rdata", bus.avms_readdata_o, 8'h00);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    #1 chk("mid rel ready0", 8'(bus.ready), 8'd0);
    @(negedge clk);
    chk("mid rel ready1", 8'(bus.ready), 8'd1);
    rd(ADDR_STATUS, 8'h01, "mid rel status");
    rd(ADDR_CTRL, 8'h01, "mid rel ctrl");
    rd(ADDR_SCRATCH, 8'h00, "mid rel scratch");
    low_seen = 0;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    chk("pending lost", 8'(low_seen), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
